wb_thr_bank: RTL

// - Wishbone slave holding NCH independent high/low threshold registers, one 32-bit word per channel.
// - Parametrised successor of the single-register threshold block: adds channel count, threshold width,

---
 rtl/wb_thr_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/wb_thr_bank.sv
// Wishbone slave holding NCH high/low threshold pairs, one 32-bit word per channel.
// Optional macro WB_THR_BANK_ERR_EN: unmapped channel accesses end with wb_err_o instead of wb_ack_o.
module wb_thr_bank #(
    parameter int          NCH      = 4,
    parameter int          THR_W    = 16,
    parameter logic [15:0] HIGH_RST = 16'hFFFF,
    parameter logic [15:0] LOW_RST  = 16'h0000,
    localparam int         AW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [AW+1:0]        wb_adr_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic [31:0]          wb_dat_i,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic                 wb_stall_o,
    output logic [31:0]          wb_dat_o,
    output logic [NCH*THR_W-1:0] thr_high_o,
    output logic [NCH*THR_W-1:0] thr_low_o,
    output logic [NCH-1:0]       thr_wr_o
);

    localparam logic [AW:0] NCH_W = (AW+1)'(NCH);

    logic             en, rip, wip, rd_req, wr_req, map;
    logic             d0_vld, d0_map, ack_nxt, err_nxt, unused_bits;
    logic [AW-1:0]    idx, d0_idx;
    logic [THR_W-1:0] d0_hi, d0_lo;
    logic [31:0]      rd_word;

    assign en     = wb_cyc_i & wb_stb_i;
    assign idx    = wb_adr_i[AW+1:2];
    assign map    = ({1'b0, idx} < NCH_W);
    // Either in-progress flag blocks new requests until the strobe is released.
    assign rd_req = en & ~wb_we_i & ~rip & ~wip;
    assign wr_req = en & wb_we_i & ~rip & ~wip;

    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = ~(wb_ack_o | wb_err_o) & en;

`ifdef WB_THR_BANK_ERR_EN
    assign ack_nxt     = (rd_req & map) | (d0_vld & d0_map);
    assign err_nxt     = (rd_req & ~map) | (d0_vld & ~d0_map);
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i};
`else
    assign ack_nxt     = rd_req | d0_vld;
    assign err_nxt     = 1'b0;
    assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i, map, d0_map};
`endif

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NCH; k++) begin
            if (idx == AW'(k)) begin
                rd_word[16 +: THR_W] = thr_high_o[k*THR_W +: THR_W];
                rd_word[0 +: THR_W]  = thr_low_o[k*THR_W +: THR_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rip      <= 1'b0;
            wip      <= 1'b0;
            d0_vld   <= 1'b0;
            d0_map   <= 1'b0;
            d0_idx   <= '0;
            d0_hi    <= '0;
            d0_lo    <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            rip      <= en & (rip | ~wb_we_i);
            wip      <= en & (wip | wb_we_i);
            d0_vld   <= wr_req;
            wb_ack_o <= ack_nxt;
            wb_err_o <= err_nxt;
            wb_dat_o <= rd_req ? rd_word : 32'h0;
            if (wr_req) begin
                d0_idx <= idx;
                d0_map <= map;
                d0_hi  <= wb_dat_i[16 +: THR_W];
                d0_lo  <= wb_dat_i[0 +: THR_W];
            end
        end
    end

    // Unmapped indices never match a channel, so their writes fall through silently.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            thr_high_o <= {NCH{HIGH_RST[THR_W-1:0]}};
            thr_low_o  <= {NCH{LOW_RST[THR_W-1:0]}};
            thr_wr_o   <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                thr_wr_o[k] <= d0_vld && (d0_idx == AW'(k));
                if (d0_vld && (d0_idx == AW'(k))) begin
                    thr_high_o[k*THR_W +: THR_W] <= d0_hi;
                    thr_low_o[k*THR_W +: THR_W]  <= d0_lo;
                end
            end
        end
    end

endmodule
